bitonic_sort_pipe: RTL

- Parametrised, pipelined bitonic sorting network that generalises the fixed 4-input, 1-bit ascending sorter to N = 2**LOG_N elements of W bits.
- Sort direction is selectable per transaction.
- Each compare-exchange layer is registered; one sorted vector per cycle at full throughput.
- Valid/ready handshake on both sides; sits between a vector producer and a downstream consumer in the sort experiments datapath.

---
 rtl/bitonic_sort_pkg.sv | 35 +++
 rtl/bitonic_sort_pipe_if.sv | 24 ++
 rtl/bitonic_cmp_swap.sv | 30 +++
 rtl/bitonic_sort_pipe.sv | 84 ++++++++
 4 files changed

// File: rtl/bitonic_sort_pkg.sv
// bitonic_sort_pkg: layer schedule and compare-exchange helpers for the bitonic sorter
package bitonic_sort_pkg;
  localparam int MAX_LOG_N = 5;
  typedef enum logic {DIR_ASC = 1'b0, DIR_DESC = 1'b1} dir_e;
  function automatic int num_stages(input int log_n);
    return log_n * (log_n + 1) / 2;
  endfunction
  // Layers run k = 2,4,..,N with j = k/2 down to 1; the prefix is the same for every N.
  function automatic int stage_k(input int stage);
    int s = 0;
    int r = 2;
    for (int lk = 1; lk <= MAX_LOG_N; lk++)
      for (int lj = lk - 1; lj >= 0; lj--) begin
        if (s == stage) r = 1 << lk;
        s++;
      end
    return r;
  endfunction
  function automatic int stage_j(input int stage);
    int s = 0;
    int r = 1;
    for (int lk = 1; lk <= MAX_LOG_N; lk++)
      for (int lj = lk - 1; lj >= 0; lj--) begin
        if (s == stage) r = 1 << lj;
        s++;
      end
    return r;
  endfunction
  function automatic int pair_partner(input int stage, input int i);
    return i ^ stage_j(stage);
  endfunction
  function automatic dir_e pair_dir(input int stage, input int i);
    return ((i & stage_k(stage)) != 0) ? DIR_DESC : DIR_ASC;
  endfunction
endpackage

// File: rtl/bitonic_sort_pipe_if.sv
// bitonic_sort_pipe_if: vector in/out handshake bundle; BITONIC_SORT_TAG_EN adds out_tag
interface bitonic_sort_pipe_if #(parameter int LOG_N = 2, parameter int W = 4);
  localparam int N = 2 ** LOG_N;
  logic in_valid, in_ready, in_desc;
  logic out_valid, out_ready, out_desc;
  logic [N*W-1:0] in_data, out_data;
`ifdef BITONIC_SORT_TAG_EN
  logic [N*LOG_N-1:0] out_tag;
`endif
  modport master (
    output in_valid, in_desc, in_data, out_ready,
    input in_ready, out_valid, out_desc, out_data
`ifdef BITONIC_SORT_TAG_EN
    , input out_tag
`endif
  );
  modport slave (
    input in_valid, in_desc, in_data, out_ready,
    output in_ready, out_valid, out_desc, out_data
`ifdef BITONIC_SORT_TAG_EN
    , output out_tag
`endif
  );
endinterface

// File: rtl/bitonic_cmp_swap.sv
// bitonic_cmp_swap: one compare-exchange; dir=1 puts the max at lo; BITONIC_SORT_TAG_EN swaps tags too
module bitonic_cmp_swap #(
  parameter int W = 4
`ifdef BITONIC_SORT_TAG_EN
  , parameter int TW = 1
`endif
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
`ifdef BITONIC_SORT_TAG_EN
  input  logic [TW-1:0] ta,
  input  logic [TW-1:0] tb,
  output logic [TW-1:0] tlo,
  output logic [TW-1:0] thi,
`endif
  input  logic          dir,
  output logic [W-1:0]  lo,
  output logic [W-1:0]  hi
);
  logic swap;
  always_comb begin
    swap = dir ? (a < b) : (a > b);
    lo = swap ? b : a;
    hi = swap ? a : b;
`ifdef BITONIC_SORT_TAG_EN
    tlo = swap ? tb : ta;
    thi = swap ? ta : tb;
`endif
  end
endmodule

// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe: registered bitonic network, one layer per stage; BITONIC_SORT_TAG_EN adds out_tag
module bitonic_sort_pipe
  import bitonic_sort_pkg::*;
#(
  parameter int LOG_N = 2,
  parameter int W = 4
) (
  input logic clk,
  input logic rst,
  bitonic_sort_pipe_if.slave io
);
  localparam int N = 2 ** LOG_N;
  localparam int S = num_stages(LOG_N);
  localparam int NW = N * W;
  logic en;
  logic [S-1:0] vq, cq, sc;
  logic [S-1:0][NW-1:0] dq, sd, nd;
`ifdef BITONIC_SORT_TAG_EN
  logic [S-1:0][N*LOG_N-1:0] tq, st, nt;
  assign io.out_tag = tq[S-1];
`endif
  assign en = !vq[S-1] || io.out_ready;
  assign io.in_ready = en;
  assign io.out_valid = vq[S-1];
  assign io.out_desc = cq[S-1];
  assign io.out_data = dq[S-1];
  for (genvar s = 0; s < S; s++) begin : g_stg
    if (s == 0) begin : g_in
      assign sd[s] = io.in_data;
      assign sc[s] = io.in_desc;
`ifdef BITONIC_SORT_TAG_EN
      for (genvar i = 0; i < N; i++) begin : g_id
        assign st[s][i*LOG_N +: LOG_N] = LOG_N'(i);
      end
`endif
    end else begin : g_q
      assign sd[s] = dq[s-1];
      assign sc[s] = cq[s-1];
`ifdef BITONIC_SORT_TAG_EN
      assign st[s] = tq[s-1];
`endif
    end
    for (genvar p = 0; p < N / 2; p++) begin : g_cs
      localparam int J = pair_partner(s, 0);
      localparam int L = (p / J) * 2 * J + p % J;
      localparam int H = pair_partner(s, L);
      // in_desc flips every local direction, which turns the whole result descending
      bitonic_cmp_swap #(
        .W(W)
`ifdef BITONIC_SORT_TAG_EN
        , .TW(LOG_N)
`endif
      ) u_cs (
        .a(sd[s][L*W +: W]),
        .b(sd[s][H*W +: W]),
`ifdef BITONIC_SORT_TAG_EN
        .ta(st[s][L*LOG_N +: LOG_N]),
        .tb(st[s][H*LOG_N +: LOG_N]),
        .tlo(nt[s][L*LOG_N +: LOG_N]),
        .thi(nt[s][H*LOG_N +: LOG_N]),
`endif
        .dir(logic'(pair_dir(s, L)) ^ sc[s]),
        .lo(nd[s][L*W +: W]),
        .hi(nd[s][H*W +: W])
      );
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      vq <= '0;
      cq <= '0;
      dq <= '0;
`ifdef BITONIC_SORT_TAG_EN
      tq <= '0;
`endif
    end else if (en) begin
      vq <= S'({vq, io.in_valid});
      cq <= sc;
      dq <= nd;
`ifdef BITONIC_SORT_TAG_EN
      tq <= nt;
`endif
    end
endmodule
